// File: rtl/mem_arbiter_configure.sv
// mem_arbiter sizing constants.
// Shared by the wires package and every arbiter file.
package mem_arbiter_configure;

  localparam int XLEN = 32;
  localparam int STRB = XLEN / 8;

endpackage

// File: rtl/mem_arbiter_wires.sv
// mem_arbiter bus types, FSM encodings and buffer entry.
// Request/response structs are shared with the requesters.
package mem_arbiter_wires;

  import mem_arbiter_configure::*;

  typedef struct packed {
    logic            mem_valid;
    logic            mem_fence;
    logic            mem_spec;
    logic            mem_instr;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [STRB-1:0] mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;
  } mem_out_type;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic       pending;
    mem_in_type req;
  } arb_buf_type;

  localparam mem_in_type  mem_in_init  = '0;
  localparam mem_out_type mem_out_init = '0;
  localparam arb_buf_type arb_buf_init = '0;

endpackage

// File: rtl/mem_arbiter_buffer.sv
// One-entry request holder for one arbiter port.
// Ports: clock, reset (sync, active-low); req live
// request; clear drops the entry when the transfer
// completes; entry is the held request + pending.
module mem_arbiter_buffer
  import mem_arbiter_wires::*;
(
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  req,
  input  logic        clear,
  output arb_buf_type entry
);

  // While pending, further valids are ignored so a
  // requester holding valid never issues twice.
  // clear wins over capture: a live request that
  // completes in its grant cycle is never stored.
  always_ff @(posedge clock) begin
    if (!reset) begin
      entry <= arb_buf_init;
    end else if (clear) begin
      entry <= arb_buf_init;
    end else if (req.mem_valid && !entry.pending) begin
      entry <= {1'b1, req};
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) to one memory arbiter.
// Ports: clock, reset (sync, active-low);
//   iport_in/iport_out  instruction requester
//   dport_in/dport_out  data requester
//   mem_in/mem_out      shared memory bus
// Zero-cycle grant from IDLE; responses routed
// combinationally to the owner only.
// Macro MEM_ARBITER_RR_EN: round-robin between
// simultaneous candidates; otherwise data wins.
module mem_arbiter
  import mem_arbiter_wires::*;
(
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  iport_in,
  output mem_out_type iport_out,
  input  mem_in_type  dport_in,
  output mem_out_type dport_out,
  input  mem_out_type mem_out,
  output mem_in_type  mem_in
);

  arb_state_t  state;
  arb_buf_type ibuf;
  arb_buf_type dbuf;

  logic cand_i;
  logic cand_d;
  logic grant_i;
  logic grant_d;
  logic own_i;
  logic own_d;
  logic done_i;
  logic done_d;

`ifdef MEM_ARBITER_RR_EN
  // 0: instruction preferred next, 1: data.
  logic rr_ptr;
`endif

  mem_arbiter_buffer u_ibuf (
    .clock (clock),
    .reset (reset),
    .req   (iport_in),
    .clear (done_i),
    .entry (ibuf)
  );

  mem_arbiter_buffer u_dbuf (
    .clock (clock),
    .reset (reset),
    .req   (dport_in),
    .clear (done_d),
    .entry (dbuf)
  );

  always_comb begin
    cand_i  = ibuf.pending | iport_in.mem_valid;
    cand_d  = dbuf.pending | dport_in.mem_valid;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (reset && state == IDLE) begin
`ifdef MEM_ARBITER_RR_EN
      if (cand_i && cand_d) begin
        grant_i = ~rr_ptr;
        grant_d = rr_ptr;
      end else begin
        grant_i = cand_i;
        grant_d = cand_d;
      end
`else
      grant_d = cand_d;
      grant_i = cand_i & ~cand_d;
`endif
    end
  end

  always_comb begin
    own_i  = grant_i | (state == BUSY_I);
    own_d  = grant_d | (state == BUSY_D);
    done_i = reset & own_i & mem_out.mem_ready;
    done_d = reset & own_d & mem_out.mem_ready;
  end

  // A fresh request granted from IDLE is not yet in
  // its buffer, so it is forwarded from the port.
  always_comb begin
    mem_in = mem_in_init;
    if (reset) begin
      unique case (1'b1)
        grant_i: begin
          mem_in = ibuf.pending ? ibuf.req : iport_in;
        end
        grant_d: begin
          mem_in = dbuf.pending ? dbuf.req : dport_in;
        end
        (state == BUSY_I): begin
          mem_in           = ibuf.req;
          mem_in.mem_valid = 1'b1;
        end
        (state == BUSY_D): begin
          mem_in           = dbuf.req;
          mem_in.mem_valid = 1'b1;
        end
        default: begin
          mem_in = mem_in_init;
        end
      endcase
    end
  end

  always_comb begin
    iport_out = done_i ? mem_out : mem_out_init;
    dport_out = done_d ? mem_out : mem_out_init;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
`ifdef MEM_ARBITER_RR_EN
      rr_ptr <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_i && !mem_out.mem_ready) begin
            state <= BUSY_I;
          end else if (grant_d && !mem_out.mem_ready) begin
            state <= BUSY_D;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_out.mem_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
`ifdef MEM_ARBITER_RR_EN
      if (grant_i) begin
        rr_ptr <= 1'b1;
      end else if (grant_d) begin
        rr_ptr <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter.
// Build with or without MEM_ARBITER_RR_EN.
module tb_mem_arbiter;

  import mem_arbiter_wires::*;

  typedef struct {
    logic       port;
    mem_in_type req;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  mem_in_type  iport_in;
  mem_in_type  dport_in;
  mem_in_type  mem_in;
  mem_out_type iport_out;
  mem_out_type dport_out;
  mem_out_type mem_out;

  int   checks = 0;
  int   errors = 0;
  int   mem_lat = 1;
  int   wait_cnt = 0;
  logic force_ready = 1'b0;

  exp_t        sb[$];
  exp_t        mon_e;
  mem_out_type mon_o;

  always #5 clock = ~clock;

  mem_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .iport_in  (iport_in),
    .iport_out (iport_out),
    .dport_in  (dport_in),
    .dport_out (dport_out),
    .mem_out   (mem_out),
    .mem_in    (mem_in)
  );

  // Memory: ready after mem_lat waiting cycles.
  always @(posedge clock) begin
    if (mem_in.mem_valid && !mem_out.mem_ready)
      wait_cnt <= wait_cnt + 1;
    else
      wait_cnt <= 0;
  end

  always_comb begin
    mem_out = mem_out_init;
    if ((mem_in.mem_valid && wait_cnt >= mem_lat)
        || force_ready) begin
      mem_out.mem_ready = 1'b1;
      mem_out.mem_rdata =
        mem_in.mem_addr ^ 32'hDEADBFEF;
    end
  end

  // Scoreboard: pop on each completed transfer.
  always @(negedge clock) begin
    if (reset) begin
      if (mem_in.mem_valid && mem_out.mem_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected addr=%h",
                   mem_in.mem_addr);
        end else begin
          mon_e = sb.pop_front();
          if (mem_in !== mon_e.req) begin
            errors++;
            $display("FAIL sb_req got=%h want=%h",
                     mem_in, mon_e.req);
          end
          mon_o.mem_ready = 1'b1;
          mon_o.mem_rdata =
            mon_e.req.mem_addr ^ 32'hDEADBFEF;
          checks++;
          if (mon_e.port) begin
            if (dport_out !== mon_o ||
                iport_out !== mem_out_init) begin
              errors++;
              $display("FAIL sb_route_d i=%h d=%h want_d=%h",
                       iport_out, dport_out, mon_o);
            end
          end else begin
            if (iport_out !== mon_o ||
                dport_out !== mem_out_init) begin
              errors++;
              $display("FAIL sb_route_i i=%h d=%h want_i=%h",
                       iport_out, dport_out, mon_o);
            end
          end
        end
      end else begin
        checks++;
        if (iport_out !== mem_out_init ||
            dport_out !== mem_out_init) begin
          errors++;
          $display("FAIL no_xfer_route i=%h d=%h want=0",
                   iport_out, dport_out);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic mem_in_type mk(
    input logic        instr,
    input logic        fence,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [3:0]  wstrb
  );
    mem_in_type r;
    r           = mem_in_init;
    r.mem_valid = 1'b1;
    r.mem_instr = instr;
    r.mem_fence = fence;
    r.mem_addr  = addr;
    r.mem_wdata = wdata;
    r.mem_wstrb = wstrb;
    return r;
  endfunction

  task automatic test_reset();
    reset       = 1'b0;
    force_ready = 1'b1;
    iport_in    = mk(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    dport_in    = mk(1'b0, 1'b1, 32'h200, 32'h55, 4'hF);
    tick();
    tick();
    #2;
    checks++;
    if (mem_in !== mem_in_init ||
        iport_out !== mem_out_init ||
        dport_out !== mem_out_init) begin
      errors++;
      $display("FAIL reset_outputs mem_in=%h i=%h d=%h want=0",
               mem_in, iport_out, dport_out);
    end
    iport_in = mem_in_init;
    dport_in = mem_in_init;
    tick();
    reset = 1'b1;
    tick();
    #2;
    checks++;
    if (mem_in !== mem_in_init) begin
      errors++;
      $display("FAIL reset_no_pending mem_in=%h want=0",
               mem_in);
    end
    tick();
    force_ready = 1'b0;
  endtask

  task automatic test_single_instr();
    int seen;
    mem_lat = 2;
    tick();
    iport_in = mk(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    sb.push_back('{port: 1'b0, req: iport_in});
    #2;
    checks++;
    if (mem_in !== iport_in) begin
      errors++;
      $display("FAIL single_grant got=%h want=%h",
               mem_in, iport_in);
    end
    tick();
    iport_in = mem_in_init;
    seen = -1;
    for (int k = 1; k < 12 && seen < 0; k++) begin
      #2;
      if (iport_out.mem_ready === 1'b1) begin
        seen = k;
        checks++;
        if (iport_out.mem_rdata !== 32'hDEADBEEF ||
            dport_out.mem_ready !== 1'b0) begin
          errors++;
          $display("FAIL single_rdata got=%h d_rdy=%b want=deadbeef d_rdy=0",
                   iport_out.mem_rdata, dport_out.mem_ready);
        end
      end
      tick();
    end
    checks++;
    if (seen != 2) begin
      errors++;
      $display("FAIL single_latency got=%0d want=2", seen);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] first;
    reset = 1'b0;
    tick();
    reset   = 1'b1;
    mem_lat = 1;
    iport_in = mk(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    dport_in = mk(1'b0, 1'b0, 32'h20, 32'hCAFEF00D, 4'hF);
`ifdef MEM_ARBITER_RR_EN
    first = 32'h10;
    sb.push_back('{port: 1'b0, req: iport_in});
    sb.push_back('{port: 1'b1, req: dport_in});
`else
    first = 32'h20;
    sb.push_back('{port: 1'b1, req: dport_in});
    sb.push_back('{port: 1'b0, req: iport_in});
`endif
    #2;
    checks++;
    if (mem_in.mem_valid !== 1'b1 ||
        mem_in.mem_addr !== first) begin
      errors++;
      $display("FAIL simul_first got=%h want=%h",
               mem_in.mem_addr, first);
    end
    tick();
    iport_in = mem_in_init;
    dport_in = mem_in_init;
    for (int k = 0; k < 20 && sb.size() != 0; k++)
      tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL simul_drain left=%0d want=0",
               sb.size());
    end
  endtask

  task automatic test_back_to_back_hold();
    int extra;
    mem_lat = 5;
    tick();
    iport_in = mk(1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
    sb.push_back('{port: 1'b0, req: iport_in});
    tick();
    iport_in = mem_in_init;
    dport_in = mk(1'b0, 1'b0, 32'h90, 32'h11223344, 4'h3);
    sb.push_back('{port: 1'b1, req: dport_in});
    tick();
    tick();
    tick();
    dport_in = mem_in_init;
    for (int k = 0; k < 30 && sb.size() != 0; k++)
      tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL hold_drain left=%0d want=0",
               sb.size());
    end
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      #2;
      if (mem_in.mem_valid === 1'b1) extra++;
      tick();
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL hold_dup got=%0d want=0", extra);
    end
  endtask

  task automatic test_same_cycle();
    mem_lat = 0;
    tick();
    iport_in = mk(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    sb.push_back('{port: 1'b0, req: iport_in});
    #2;
    checks++;
    if (iport_out.mem_ready !== 1'b1 ||
        iport_out.mem_rdata !== (32'h40 ^ 32'hDEADBFEF) ||
        mem_in.mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle i=%h valid=%b",
               iport_out, mem_in.mem_valid);
    end
    tick();
    iport_in = mem_in_init;
    dport_in = mk(1'b0, 1'b0, 32'h44, 32'h0BADF00D, 4'h1);
    sb.push_back('{port: 1'b1, req: dport_in});
    #2;
    checks++;
    if (mem_in !== dport_in) begin
      errors++;
      $display("FAIL same_cycle_idle got=%h want=%h",
               mem_in, dport_in);
    end
    tick();
    dport_in = mem_in_init;
    #2;
    checks++;
    if (mem_in.mem_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL same_cycle_done valid=%b left=%0d want=0",
               mem_in.mem_valid, sb.size());
    end
  endtask

  task automatic test_reset_busy();
    int bad;
    mem_lat = 10;
    tick();
    dport_in = mk(1'b0, 1'b0, 32'h60, 32'h600D, 4'hF);
    tick();
    dport_in = mem_in_init;
    #2;
    checks++;
    if (mem_in.mem_valid !== 1'b1 ||
        mem_in.mem_addr !== 32'h60) begin
      errors++;
      $display("FAIL rst_busy_pre got=%h want addr 60",
               mem_in);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (mem_in !== mem_in_init ||
        dport_out !== mem_out_init) begin
      errors++;
      $display("FAIL rst_busy_out mem_in=%h d=%h want=0",
               mem_in, dport_out);
    end
    tick();
    reset       = 1'b1;
    force_ready = 1'b1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      #2;
      if (mem_in.mem_valid !== 1'b0 ||
          iport_out.mem_ready !== 1'b0 ||
          dport_out.mem_ready !== 1'b0) bad++;
      tick();
    end
    force_ready = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_busy_stale got=%0d want=0", bad);
    end
  endtask

  task automatic test_fence();
    int vcnt;
    int bad;
    mem_lat = 3;
    tick();
    dport_in = mk(1'b0, 1'b1, 32'h70, 32'hA5A55A5A, 4'h3);
    dport_in.mem_spec = 1'b1;
    sb.push_back('{port: 1'b1, req: dport_in});
    vcnt = 0;
    bad  = 0;
    for (int k = 0; k < 10; k++) begin
      #2;
      if (mem_in.mem_valid === 1'b1) begin
        vcnt++;
        if (mem_in.mem_fence !== 1'b1 ||
            mem_in.mem_spec !== 1'b1 ||
            mem_in.mem_wstrb !== 4'h3 ||
            mem_in.mem_wdata !== 32'hA5A55A5A) bad++;
      end
      tick();
      if (k == 0) dport_in = mem_in_init;
    end
    checks++;
    if (bad != 0 || vcnt != 4) begin
      errors++;
      $display("FAIL fence bad=%0d cycles=%0d want 0/4",
               bad, vcnt);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL fence_drain left=%0d want=0",
               sb.size());
    end
  endtask

  initial begin
    iport_in = mem_in_init;
    dport_in = mem_in_init;
    test_reset();
    test_single_instr();
    test_simultaneous();
    test_back_to_back_hold();
    test_same_cycle();
    test_reset_busy();
    test_fence();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
